// File: rtl/gcd_arbiter.sv
// gcd_arbiter: shares one GCD core between NREQ round-robin requesters.
// Each result is returned tagged with its requester ID; a watchdog aborts a core that never finishes.
module gcd_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*W-1:0] REQ_X,
    input  logic [NREQ*W-1:0] REQ_Y,
    output logic [NREQ-1:0]   GNT,
    output logic              RESP_VALID,
    output logic [IDW-1:0]    RESP_ID,
    output logic [W-1:0]      RESP_GCD,
    output logic              RESP_ERR,
    output logic [W-1:0]      GCD_X,
    output logic [W-1:0]      GCD_Y,
    output logic              GCD_START,
    input  logic              GCD_DONE,
    input  logic [W-1:0]      GCD_RESULT
);
    localparam int             WDW      = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST  = WDW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] PTR_INIT = IDW'(NREQ - 1);

    // Handshakes: a REQ bit is a level held until its one-cycle GNT pulse; GNT is raised only in
    // IDLE and the operands are captured at the edge that ends the GNT cycle. RESP_VALID is a
    // one-cycle strobe with no backpressure. GCD_START is high for the whole RUN state, and
    // RELEASE waits for GCD_DONE low so the core is re-armed before the next START.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_RESP, S_RELEASE} state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   y_q, y_d;
    logic [W-1:0]   res_q, res_d;
    logic           err_q, err_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic [W-1:0]    req_x_a [NREQ];
    logic [W-1:0]    req_y_a [NREQ];
    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic [IDW-1:0]  cand_idx;
    logic [W-1:0]    pick_x, pick_y;
    logic [NREQ-1:0] gnt;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign req_x_a[g] = REQ_X[g*W +: W];
        assign req_y_a[g] = REQ_Y[g*W +: W];
    end

    // Round-robin search starts just after the last granted index and wraps.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!pick_found && REQ[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    assign pick_x = req_x_a[pick_idx];
    assign pick_y = req_y_a[pick_idx];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        x_d     = x_q;
        y_d     = y_q;
        res_d   = res_q;
        err_d   = err_q;
        wd_d    = wd_q;
        gnt     = '0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    gnt   = NREQ'(1) << pick_idx;
                    x_d   = pick_x;
                    y_d   = pick_y;
                    id_d  = pick_idx;
                    ptr_d = pick_idx;
                    err_d = 1'b0;
                    wd_d  = '0;
                    if (pick_x != '0 && pick_y != '0) begin
                        state_d = S_RUN;
                    end else begin
                        // gcd(0,y)=y and gcd(0,0)=0, so the core is not needed.
                        res_d   = pick_x | pick_y;
                        state_d = S_RESP;
                    end
                end
            end
            S_RUN: begin
                if (GCD_DONE) begin
                    res_d   = GCD_RESULT;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wd_q == WD_LAST) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_RESP: begin
                wd_d    = '0;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!GCD_DONE) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_INIT;
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    // No grant is offered while reset is being applied.
    assign GNT        = RESET ? '0 : gnt;
    assign GCD_START  = (state_q == S_RUN);
    assign GCD_X      = x_q;
    assign GCD_Y      = y_q;
    assign RESP_VALID = (state_q == S_RESP);
    assign RESP_ID    = RESP_VALID ? id_q : '0;
    assign RESP_GCD   = RESP_VALID ? res_q : '0;
    assign RESP_ERR   = RESP_VALID & err_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: requesters and a behavioural GCD core with programmable latency,
// a round-robin reference model feeding expected queues, and a monitor that checks every grant/result.
module tb_gcd_arbiter;
  localparam int NREQ    = 4;
  localparam int W       = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 8;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [W-1:0]   g;
    logic           err;
    logic [7:0]     starts;
  } exp_t;

  logic              clk = 1'b0;
  logic              RESET;
  logic [NREQ-1:0]   REQ;
  logic [NREQ*W-1:0] REQ_X;
  logic [NREQ*W-1:0] REQ_Y;
  logic [NREQ-1:0]   GNT;
  logic              RESP_VALID;
  logic [IDW-1:0]    RESP_ID;
  logic [W-1:0]      RESP_GCD;
  logic              RESP_ERR;
  logic [W-1:0]      GCD_X;
  logic [W-1:0]      GCD_Y;
  logic              GCD_START;
  logic              GCD_DONE;
  logic [W-1:0]      GCD_RESULT;

  gcd_arbiter #(.NREQ(NREQ), .W(W), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(clk), .RESET(RESET), .REQ(REQ), .REQ_X(REQ_X), .REQ_Y(REQ_Y), .GNT(GNT),
    .RESP_VALID(RESP_VALID), .RESP_ID(RESP_ID), .RESP_GCD(RESP_GCD), .RESP_ERR(RESP_ERR),
    .GCD_X(GCD_X), .GCD_Y(GCD_Y), .GCD_START(GCD_START), .GCD_DONE(GCD_DONE),
    .GCD_RESULT(GCD_RESULT)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- per-requester stimulus table ----------------
  logic [W-1:0] bx [NREQ];
  logic [W-1:0] by [NREQ];
  logic [7:0]   bl [NREQ];    // core latency; 0 means the core never finishes
  logic [1:0]   blin [NREQ];  // cycles DONE lingers after START drops

  // ---------------- scoreboard state ----------------
  exp_t           exp_q[$];
  logic [IDW-1:0] exp_gnt_q[$];
  int             ref_ptr = NREQ - 1;
  int             n_checks = 0;
  int             n_err = 0;
  bit             end_req = 1'b0;
  bit             end_done = 1'b0;
  bit             rst_sampled = 1'b0;

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    int p, q, t;
    p = a;
    q = b;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return W'(p);
  endfunction

  // ---------------- behavioural GCD core ----------------
  logic [7:0] cur_lat = '0;
  logic [1:0] cur_lin = '0;
  logic [7:0] run_cnt = '0;
  logic [1:0] linger = '0;

  always @(posedge clk) begin
    if (RESET) begin
      run_cnt <= '0;
      linger  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (GNT[i]) begin
          cur_lat <= bl[i];
          cur_lin <= blin[i];
        end
      end
      if (GCD_START) begin
        run_cnt <= run_cnt + 8'd1;
        if (GCD_DONE) linger <= cur_lin;
      end else begin
        run_cnt <= '0;
        if (linger != 2'd0) linger <= linger - 2'd1;
      end
    end
  end

  assign GCD_DONE   = GCD_START ? (cur_lat != 8'd0 && (run_cnt + 8'd1) >= cur_lat) : (linger != 2'd0);
  assign GCD_RESULT = ref_gcd(GCD_X, GCD_Y);

  // ---------------- reference model ----------------
  function automatic exp_t model(input int id);
    exp_t e;
    e.id = IDW'(id);
    e.x  = bx[id];
    e.y  = by[id];
    if (bx[id] == '0 || by[id] == '0) begin
      e.g = bx[id] | by[id];
      e.err = 1'b0;
      e.starts = 8'd0;
    end else if (bl[id] >= 8'd1 && bl[id] <= 8'(TIMEOUT)) begin
      e.g = ref_gcd(bx[id], by[id]);
      e.err = 1'b0;
      e.starts = bl[id];
    end else begin
      e.g = '0;
      e.err = 1'b1;
      e.starts = 8'(TIMEOUT);
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  int   cyc = 0;
  int   gnt_cyc = 0;
  int   starts_seen = 0;
  int   stall = 0;
  exp_t cur_e;
  logic [IDW-1:0] cur_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) rst_sampled <= RESET;

  always @(negedge clk) begin
    cyc++;
    if (rst_sampled) begin
      chk("reset_outputs", {GNT, RESP_VALID, RESP_ID, RESP_GCD, RESP_ERR, GCD_X, GCD_Y, GCD_START}, 0);
      stall = 0;
    end else begin
      if (GNT != '0) begin
        if (exp_gnt_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_gnt: got GNT=%b with no grant expected (cycle %0d)", GNT, cyc);
        end else begin
          cur_id = exp_gnt_q.pop_front();
          chk("gnt_onehot", 32'(GNT), 32'(1) << cur_id);
        end
        chk("gnt_done_low", 32'(GCD_DONE), 0);
        gnt_cyc = cyc;
        starts_seen = 0;
      end
      if (GCD_START) begin
        if (starts_seen == 0 && exp_q.size() > 0)
          chk("core_operands", {GCD_X, GCD_Y}, {exp_q[0].x, exp_q[0].y});
        starts_seen++;
      end
      if (RESP_VALID) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_resp: got id=%0d gcd=%0d with no result expected (cycle %0d)",
                   RESP_ID, RESP_GCD, cyc);
        end else begin
          cur_e = exp_q.pop_front();
          chk("resp_id", 32'(RESP_ID), 32'(cur_e.id));
          chk("resp_gcd", 32'(RESP_GCD), 32'(cur_e.g));
          chk("resp_err", 32'(RESP_ERR), 32'(cur_e.err));
          chk("start_cycles", starts_seen, 32'(cur_e.starts));
          chk("resp_latency", cyc - gnt_cyc, 32'(cur_e.starts) + 1);
        end
      end
      if ((exp_q.size() > 0 || REQ != '0) && GNT == '0 && !RESP_VALID) stall++;
      else stall = 0;
      if (stall > 150) begin
        n_checks++;
        n_err++;
        $display("FAIL stall: %0d results outstanding, REQ=%b, no progress for %0d cycles",
                 exp_q.size(), REQ, stall);
        exp_q.delete();
        exp_gnt_q.delete();
        stall = 0;
      end
    end
    if (end_req && !end_done) begin
      chk("drained", exp_q.size() + exp_gnt_q.size(), 0);
      end_done = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input int x, input int y, input int lat, input int lin);
    bx[i]   = W'(x);
    by[i]   = W'(y);
    bl[i]   = 8'(lat);
    blin[i] = 2'(lin);
  endtask

  task automatic drive_operands();
    for (int i = 0; i < NREQ; i++) begin
      REQ_X[i*W +: W] = bx[i];
      REQ_Y[i*W +: W] = by[i];
    end
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    REQ = '0;
    exp_q.delete();
    exp_gnt_q.delete();
    ref_ptr = NREQ - 1;
    repeat (n) @(posedge clk);
    #1 RESET = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    logic [NREQ-1:0] g;
    budget = 400;
    while ((REQ != '0 || exp_q.size() != 0) && budget > 0) begin
      @(negedge clk) g = GNT;
      @(posedge clk);
      #1 REQ = REQ & ~g;
      budget--;
    end
    if (budget == 0) REQ = '0;
  endtask

  task automatic run_batch(input logic [NREQ-1:0] mask);
    logic [NREQ-1:0] pend;
    int pick;
    pend = mask;
    while (pend != '0) begin
      pick = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (ref_ptr + k) % NREQ;
        if (pick < 0 && pend[c]) pick = c;
      end
      pend[pick] = 1'b0;
      ref_ptr = pick;
      exp_gnt_q.push_back(IDW'(pick));
      exp_q.push_back(model(pick));
    end
    @(posedge clk);
    #1;
    drive_operands();
    REQ = mask;
    wait_drain();
  endtask

  // Grant one requester with a core that never finishes, then reset mid-computation.
  task automatic reset_during_run(input int id);
    logic [NREQ-1:0] g;
    bit seen;
    int budget;
    @(posedge clk);
    #1;
    exp_gnt_q.push_back(IDW'(id));
    ref_ptr = id;
    drive_operands();
    REQ = NREQ'(1) << id;
    seen = 1'b0;
    budget = 20;
    while (!seen && budget > 0) begin
      @(negedge clk) begin
        g = GNT;
        seen = GCD_START;
      end
      @(posedge clk);
      #1 REQ = REQ & ~g;
      budget--;
    end
    do_reset(2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    RESET = 1'b1;
    REQ   = '0;
    REQ_X = '0;
    REQ_Y = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1, 1, 1, 0);
    do_reset(3);

    set_req(0, 4, 6, 5, 1);
    run_batch(4'b0001);

    do_reset(1);
    set_req(0, 4, 6, 3, 2);
    set_req(1, 9, 6, 4, 2);
    set_req(2, 8, 12, 2, 2);
    set_req(3, 7, 5, 1, 2);
    run_batch(4'b1111);

    set_req(0, 5, 15, 2, 0);
    set_req(3, 12, 8, 3, 1);
    run_batch(4'b1001);

    set_req(2, 0, 9, 3, 0);
    run_batch(4'b0100);

    set_req(0, 0, 0, 3, 0);
    run_batch(4'b0001);

    set_req(1, 5, 10, 0, 0);
    run_batch(4'b0010);

    set_req(2, 6, 9, TIMEOUT, 1);
    run_batch(4'b0100);

    set_req(2, 3, 6, 0, 0);
    reset_during_run(2);
    set_req(0, 10, 4, 2, 0);
    set_req(3, 14, 7, 3, 1);
    run_batch(4'b1001);

    repeat (40) begin
      for (int i = 0; i < NREQ; i++) begin
        r = $urandom_range(0, 9);
        set_req(i, $urandom_range(0, 15), $urandom_range(0, 15),
                (r == 0) ? 0 : (r == 1) ? TIMEOUT : (r == 2) ? TIMEOUT + 2 : $urandom_range(1, 6),
                $urandom_range(0, 3));
      end
      run_batch(NREQ'($urandom_range(1, (1 << NREQ) - 1)));
    end

    @(posedge clk);
    #1 end_req = 1'b1;
    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
